// File: rtl/axis_fifo_pkg.sv
// Shared helpers and reset constants for the synchronous AXI-Stream FIFO.
// Optional store-and-forward build: define AXIS_FIFO_PACKET_MODE_EN.
package axis_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam logic RST_S_READY = 1'b0;
    localparam logic RST_FULL    = 1'b0;
    localparam logic RST_EMPTY   = 1'b1;
    localparam logic RST_AFULL   = 1'b0;
    localparam logic RST_AEMPTY  = 1'b1;
    localparam logic RST_OVF     = 1'b0;
    localparam logic RST_UNF     = 1'b0;

endpackage

// File: rtl/axis_fifo_sync_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register doubles as the FIFO output stage, so it is reset to zero.
module sdp_ram #(
    parameter int WIDTH      = 33,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_fifo_sync.sv
// Single-clock first-word-fall-through AXI-Stream FIFO with level and sticky error flags.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward output gating.
module axis_fifo_sync
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int AF_LEVEL   = DEPTH - 16,
    parameter int AE_LEVEL   = 16,
    parameter int PTR_WIDTH  = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [PTR_WIDTH:0]    fifo_cnt,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } axis_beat_t;

    localparam int                CW      = PTR_WIDTH + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]     AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]     AE_C    = CW'(AE_LEVEL);

    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_s_ready;
    logic          r_out_valid;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic          r_ovf;
    logic          r_unf;
    logic          w_wr;
    logic          w_rd;
    logic          w_ram_nonempty;
    logic          w_load;
    logic          w_m_valid;
    axis_beat_t    w_wr_beat;
    axis_beat_t    w_rd_beat;
    logic [$bits(axis_beat_t)-1:0] w_ram_rdata;

    assign w_wr           = s_valid & r_s_ready;
    assign w_rd           = w_m_valid & m_ready;
    assign w_ram_nonempty = (r_wr_ptr != r_rd_ptr);
    // Refill the output register whenever it is free or being drained this cycle.
    assign w_load         = w_ram_nonempty & (~r_out_valid | w_rd);
    assign w_wr_beat      = '{last: s_last, data: s_data};
    assign w_rd_beat      = axis_beat_t'(w_ram_rdata);

    sdp_ram #(
        .WIDTH      ($bits(axis_beat_t)),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr & rst_n),
        .i_wr_addr (r_wr_ptr[PTR_WIDTH-1:0]),
        .i_wr_data (w_wr_beat),
        .i_rd_en   (w_load),
        .i_rd_addr (r_rd_ptr[PTR_WIDTH-1:0]),
        .o_rd_data (w_ram_rdata)
    );

    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_wr, w_rd})
            2'b10:   w_cnt_next = r_cnt + CW'(1);
            2'b01:   w_cnt_next = r_cnt - CW'(1);
            default: w_cnt_next = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_s_ready   <= RST_S_READY;
            r_full      <= RST_FULL;
            r_empty     <= RST_EMPTY;
            r_afull     <= RST_AFULL;
            r_aempty    <= RST_AEMPTY;
            r_ovf       <= RST_OVF;
            r_unf       <= RST_UNF;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + CW'(1);
                r_out_valid <= 1'b1;
            end else if (w_rd) begin
                r_out_valid <= 1'b0;
            end
            // Flags come from the next count so they line up with the new fifo_cnt.
            r_cnt     <= w_cnt_next;
            r_s_ready <= (w_cnt_next != DEPTH_C);
            r_full    <= (w_cnt_next == DEPTH_C);
            r_empty   <= (w_cnt_next == '0);
            r_afull   <= (w_cnt_next >= AF_C);
            r_aempty  <= (w_cnt_next <= AE_C);
            if (s_valid & r_full) begin
                r_ovf <= 1'b1;
            end
            if (m_ready & ~w_m_valid & r_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [CW-1:0] r_pkt_cnt;
    logic          r_cut;
    logic          w_pkt_in;
    logic          w_pkt_out;

    assign w_pkt_in  = w_wr & s_last;
    assign w_pkt_out = w_rd & w_rd_beat.last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
            r_cut     <= 1'b0;
        end else begin
            case ({w_pkt_in, w_pkt_out})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
            // A packet larger than the FIFO is released until its tail leaves.
            if (w_pkt_out) begin
                r_cut <= 1'b0;
            end else if (r_full && (r_pkt_cnt == '0)) begin
                r_cut <= 1'b1;
            end
        end
    end

    assign w_m_valid = r_out_valid & ((r_pkt_cnt != '0) | r_cut);
`else
    assign w_m_valid = r_out_valid;
`endif

    assign s_ready      = r_s_ready;
    assign m_valid      = w_m_valid;
    assign m_data       = w_rd_beat.data;
    assign m_last       = w_rd_beat.last;
    assign fifo_cnt     = r_cnt;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Self-checking bench for axis_fifo_sync: directed phases plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_axis_fifo_sync;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          m_ready = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic [PW:0]   fifo_cnt;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    axis_fifo_sync #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_last       (s_last),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .fifo_cnt     (fifo_cnt),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue of beats tagged with the edge that accepted them.
    // A beat becomes visible at max(accept edge + 1, edge that consumed its predecessor).
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            acc;
    } beat_t;

    beat_t q[$];
    int    edge_n    = 0;
    int    last_cons = 0;
    bit    ready_en  = 1'b0;
    bit    ovf_m     = 1'b0;
    bit    unf_m     = 1'b0;
    bit    cut_m     = 1'b0;
    int    total     = 0;
    int    bad       = 0;
    int    wcount    = 0;
    int    ocount    = 0;

    function automatic int nlast();
        int n = 0;
        foreach (q[i]) if (q[i].l) n++;
        return n;
    endfunction

    function automatic bit mv_exp();
        if (q.size() == 0) return 1'b0;
        if (edge_n < q[0].acc + 1 || edge_n < last_cons) return 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
        if (nlast() == 0 && !cut_m) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit sready_exp();
        return ready_en && (q.size() != DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        bit    wr       = s_valid && sready_exp();
        bit    mv_pre   = mv_exp();
        bit    rd       = mv_pre && m_ready;
        bit    full_pre = (q.size() == DEPTH);
        bit    emp_pre  = (q.size() == 0);
        int    nl_pre   = nlast();
        bit    lastc    = 1'b0;
        beat_t b;
        edge_n++;
        if (!rst_n) begin
            q.delete();
            last_cons = edge_n;
            ready_en  = 1'b0;
            ovf_m     = 1'b0;
            unf_m     = 1'b0;
            cut_m     = 1'b0;
            return;
        end
        if (s_valid && full_pre) ovf_m = 1'b1;
        if (m_ready && !mv_pre && emp_pre) unf_m = 1'b1;
        if (rd) begin
            lastc = q[0].l;
            void'(q.pop_front());
            last_cons = edge_n;
        end
        if (rd && lastc) cut_m = 1'b0;
        else if (full_pre && nl_pre == 0) cut_m = 1'b1;
        if (wr) begin
            b.d   = s_data;
            b.l   = s_last;
            b.acc = edge_n;
            q.push_back(b);
        end
        ready_en = 1'b1;
    endtask

    task automatic check_all();
        bit mv = mv_exp();
        chk("s_ready", s_ready, sready_exp());
        chk("m_valid", m_valid, mv);
        if (mv) begin
            chk("m_data", m_data, q[0].d);
            chk("m_last", m_last, q[0].l);
        end
        chk("fifo_cnt", fifo_cnt, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("almost_full", almost_full, q.size() >= AF);
        chk("almost_empty", almost_empty, q.size() <= AE);
        chk("overflow", overflow, ovf_m);
        chk("underflow", underflow, unf_m);
    endtask

    task automatic cyc(input logic rn, input logic sv, input logic [DW-1:0] d,
                       input logic l, input logic mr);
        rst_n   = rn;
        s_valid = sv;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        // Reset held with s_valid asserted: nothing may be accepted.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b1);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("ready_after_rst", s_ready, 1);

        // Fill to full, then one more offered beat sets overflow.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
        chk("fill_cnt", fifo_cnt, DEPTH);
        cyc(1'b1, 1'b1, 16'h00ee, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1);

        // Drain in order; underflow sets once empty with m_ready held.
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("drain_empty", empty, 1);

        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Streaming at one beat per cycle.
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, DW'(i + 256), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Full boundary: single read pulse while the producer keeps offering.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, DW'(i + 512), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h0aaa, 1'b0, 1'b1);
        chk("boundary_cnt", fifo_cnt, DEPTH - 1);
        cyc(1'b1, 1'b1, 16'h0bbb, 1'b0, 1'b0);
        chk("boundary_refill", fifo_cnt, DEPTH);
        cyc(1'b1, 1'b1, 16'h0ccc, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Random traffic with 4-beat packets and 30% consumer readiness.
        wcount = 0;
        ocount = 0;
        for (int i = 0; i < 400; i++) begin
            bit sv  = ($urandom_range(0, 99) < 70);
            bit mr  = ($urandom_range(0, 99) < 30);
            bit l   = ((wcount % 4) == 3);
            bit acc = sv && sready_exp();
            if (mv_exp() && mr) begin
                chk("pkt_last_every4", m_last, (ocount % 4) == 3);
                ocount++;
            end
            cyc(1'b1, sv, DW'($urandom), l, mr);
            if (acc) wcount++;
        end

        // Reset in the middle of traffic discards everything.
        cyc(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
        chk("midrst_empty", empty, 1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, DW'(i + 4096), 1'b0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("pkt_hold", m_valid, 0);
        cyc(1'b1, 1'b1, 16'h1003, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, DW'(i + 8192), i == 3, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("pkt_rst_empty", empty, 1);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, DW'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("pkt_rst_cleared", m_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
